// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and priority helper for the 4-to-2 event encoder
//
// Purpose : code width, request count, named codes and the fixed-priority
//           selector used when loading the output slot.
// Ports   : none (package).
package encoder_pkg;

   localparam int CODE_W  = 2;
   localparam int NUM_REQ = 4;

   localparam logic [CODE_W-1:0] REQ0 = 2'd0;
   localparam logic [CODE_W-1:0] REQ1 = 2'd1;
   localparam logic [CODE_W-1:0] REQ2 = 2'd2;
   localparam logic [CODE_W-1:0] REQ3 = 2'd3;

   // Highest set index of v (3 > 2 > 1 > 0); returns REQ0 when v is empty,
   // so callers must qualify the result with |v.
   function automatic logic [CODE_W-1:0] prio_idx(input logic [NUM_REQ-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = REQ0;
      if (v[3])      idx = REQ3;
      else if (v[2]) idx = REQ2;
      else if (v[1]) idx = REQ1;
      return idx;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit synchroniser chain that resets to 1
//
// Purpose : bring one asynchronous active-low request line into the clk domain.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset, chain goes to 1 (line idle)
//           d_i  - asynchronous input
//           q_o  - synchronised output, DEPTH edges after sampling
module sync_bit #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] chain_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain_q <= '1;
      else     chain_q <= {chain_q[DEPTH-2:0], d_i};
   end

   assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/encoder4_ctrl.sv
// rtl/encoder4_ctrl.sv - sequential 4-to-2 event encoder with valid/ready output slot
//
// Purpose : synchronise four active-low request lines, detect falling edges,
//           hold each event pending and present them one at a time as a 2-bit
//           code with an active-low strobe for a 2-to-4 decoder.
// Ports   : clk      - clock, rising edge
//           rst      - asynchronous active-high reset
//           req_n    - asynchronous active-low request lines, idle high
//           ready    - consumer accepts the presented code this cycle
//           valid    - a code is presented
//           en_n     - ~valid, decoder enable
//           a, b     - code MSB / LSB, 0 while idle
//           pending  - events captured but not yet presented
//           ovf_cnt  - saturating count of events lost to an already-pending bit
module encoder4_ctrl
   import encoder_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int OVF_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req_n,
   input  logic               ready,
   output logic               valid,
   output logic               en_n,
   output logic               a,
   output logic               b,
   output logic [3:0]         pending,
   output logic [OVF_W-1:0]   ovf_cnt
);

   // Three spare bits so up to four simultaneous losses never wrap the sum.
   localparam int SUM_W = OVF_W + 3;

   logic [NUM_REQ-1:0] sync_w;
   logic [NUM_REQ-1:0] prev_q;
   logic [NUM_REQ-1:0] ev;

   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic               valid_q, valid_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [OVF_W-1:0]   ovf_q, ovf_d;

   logic               slot_free;
   logic               load;
   logic [CODE_W-1:0]  load_idx;
   logic [NUM_REQ-1:0] load_vec;
   logic [NUM_REQ-1:0] lost;
   logic [2:0]         lost_cnt;
   logic [SUM_W-1:0]   ovf_sum;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
      sync_bit #(
         .DEPTH (SYNC_STAGES)
      ) u_sync (
         .clk (clk),
         .rst (rst),
         .d_i (req_n[i]),
         .q_o (sync_w[i])
      );
   end

   always_comb begin
      ev        = ~sync_w & prev_q;
      slot_free = ~valid_q | ready;
      load      = slot_free & (|pending_q);
      load_idx  = prio_idx(pending_q);

      load_vec = '0;
      if (load) load_vec[load_idx] = 1'b1;

      // An event coinciding with the load of its own bit re-arms the bit
      // instead of being lost.
      lost      = ev & pending_q & ~load_vec;
      pending_d = (pending_q & ~load_vec) | ev;

      lost_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         lost_cnt = lost_cnt + 3'(lost[i]);
      end

      ovf_sum = SUM_W'(ovf_q) + SUM_W'(lost_cnt);
      if (|ovf_sum[SUM_W-1:OVF_W]) ovf_d = '1;
      else                         ovf_d = ovf_sum[OVF_W-1:0];

      // Presented code is frozen while valid & !ready; idle code is 0.
      valid_d = valid_q;
      code_d  = code_q;
      if (slot_free) begin
         valid_d = load;
         code_d  = load ? load_idx : REQ0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= '1;
         pending_q <= '0;
         valid_q   <= 1'b0;
         code_q    <= REQ0;
         ovf_q     <= '0;
      end else begin
         prev_q    <= sync_w;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         code_q    <= code_d;
         ovf_q     <= ovf_d;
      end
   end

   assign valid   = valid_q;
   assign en_n    = ~valid_q;
   assign a       = code_q[1];
   assign b       = code_q[0];
   assign pending = pending_q;
   assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_encoder4_ctrl.sv
// tb/tb_encoder4_ctrl.sv - self-checking bench for encoder4_ctrl with a behavioural model
module tb_encoder4_ctrl;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req_n = 4'hF;
   logic       ready = 1'b0;

   logic       valid1, en_n1, a1, b1;
   logic [3:0] pend1;
   logic [7:0] ovf1;
   logic       valid2, en_n2, a2, b2;
   logic [3:0] pend2;
   logic [1:0] ovf2;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state
   logic [3:0] samples[$];
   logic       m_valid;
   int         m_code;
   logic [3:0] m_pend;
   int         m_ovf1;
   int         m_ovf2;

   encoder4_ctrl #(.SYNC_STAGES(SYNC), .OVF_W(8)) dut1 (
      .clk(clk), .rst(rst), .req_n(req_n), .ready(ready), .valid(valid1),
      .en_n(en_n1), .a(a1), .b(b1), .pending(pend1), .ovf_cnt(ovf1)
   );

   encoder4_ctrl #(.SYNC_STAGES(SYNC), .OVF_W(2)) dut2 (
      .clk(clk), .rst(rst), .req_n(req_n), .ready(ready), .valid(valid2),
      .en_n(en_n2), .a(a2), .b(b2), .pending(pend2), .ovf_cnt(ovf2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_code  = 0;
      m_pend  = 4'h0;
      m_ovf1  = 0;
      m_ovf2  = 0;
      samples.delete();
      repeat (SYNC + 1) samples.push_back(4'hF);
   endtask

   // A line is seen by the core SYNC-1 edges after it is sampled; an event is
   // a 1 -> 0 change between two consecutive seen values.
   task automatic model_edge();
      logic [3:0] seen_now, seen_prev, ev;
      logic       free;
      int         load_idx, lost;
      if (rst) begin
         model_reset();
      end else begin
         seen_now  = samples[samples.size() - SYNC];
         seen_prev = samples[samples.size() - 1 - SYNC];
         ev        = ~seen_now & seen_prev;
         free      = !m_valid || ready;
         load_idx  = -1;
         if (free) begin
            for (int i = 3; i >= 0; i--) begin
               if (m_pend[i] && load_idx < 0) load_idx = i;
            end
         end
         lost = 0;
         for (int i = 0; i < 4; i++) begin
            if (ev[i] && m_pend[i] && i != load_idx) lost++;
         end
         for (int i = 0; i < 4; i++) begin
            if (i == load_idx) m_pend[i] = ev[i];
            else               m_pend[i] = m_pend[i] | ev[i];
         end
         m_ovf1 = (m_ovf1 + lost > 255) ? 255 : m_ovf1 + lost;
         m_ovf2 = (m_ovf2 + lost > 3) ? 3 : m_ovf2 + lost;
         if (free) begin
            m_valid = (load_idx >= 0);
            m_code  = (load_idx >= 0) ? load_idx : 0;
         end
         samples.push_back(req_n);
         void'(samples.pop_front());
      end
   endtask

   task automatic compare_all();
      chk("valid",    valid1, m_valid);
      chk("en_n",     en_n1, !m_valid);
      chk("code",     {a1, b1}, m_code);
      chk("pending",  pend1, m_pend);
      chk("ovf",      ovf1, m_ovf1);
      chk("valid_w2", valid2, m_valid);
      chk("en_n_w2",  en_n2, !m_valid);
      chk("code_w2",  {a2, b2}, m_code);
      chk("pend_w2",  pend2, m_pend);
      chk("ovf_w2",   ovf2, m_ovf2);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, valid1, 0);
      chk({tag, "_en_n"},  en_n1, 1);
      chk({tag, "_code"},  {a1, b1}, 0);
      chk({tag, "_pend"},  pend1, 0);
      chk({tag, "_ovf"},   ovf1, 0);
      chk({tag, "_ovf_w2"}, ovf2, 0);
   endtask

   initial begin
      int exp_code[8];

      model_reset();
      #1 rst = 1'b1;
      #1 chk_reset_vals("rst0");
      steps(2);
      rst = 1'b0;
      steps(3);

      // single event on bit 2
      req_n = 4'b1011;
      ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t1_valid", valid1, (k == 4));
         chk("t1_en_n",  en_n1, (k != 4));
         chk("t1_pend",  pend1, (k == 3) ? 4'b0100 : 4'b0000);
         if (k == 4) chk("t1_code", {a1, b1}, 2'b10);
      end

      // priority and drain: bits 3, 1, 0 fall together
      exp_code = '{-1, -1, -1, 3, 1, 0, -1, -1};
      req_n = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t2_valid", valid1, (exp_code[k-1] >= 0));
         if (exp_code[k-1] >= 0) chk("t2_code", {a1, b1}, exp_code[k-1]);
      end
      chk("t2_pend", pend1, 4'b0000);

      // backpressure: code 2 held while bit 3 arrives
      req_n = 4'hF;
      ready = 1'b0;
      steps(4);
      req_n = 4'b1011;
      steps(4);
      chk("t3_valid", valid1, 1);
      chk("t3_code",  {a1, b1}, 2'b10);
      req_n = 4'b0011;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t3_hold_valid", valid1, 1);
         chk("t3_hold_code",  {a1, b1}, 2'b10);
      end
      chk("t3_pend", pend1, 4'b1000);
      ready = 1'b1;
      step();
      chk("t3_next_valid", valid1, 1);
      chk("t3_next_code",  {a1, b1}, 2'b11);
      step();
      chk("t3_idle", valid1, 0);

      // overflow: bit 1 presented, pending re-armed, then losses
      req_n = 4'hF;
      steps(4);
      chk("t4_ovf0", ovf1, 0);
      ready = 1'b0;
      req_n = 4'b1101;
      steps(4);
      chk("t4_code", {a1, b1}, 2'b01);
      for (int f = 0; f < 3; f++) begin
         req_n = 4'hF;
         steps(2);
         req_n = 4'b1101;
         steps(2);
      end
      steps(3);
      chk("t4_ovf2",  ovf1, 2);
      chk("t4_ovf2b", ovf2, 2);
      chk("t4_pend",  pend1, 4'b0010);
      for (int f = 0; f < 3; f++) begin
         req_n = 4'hF;
         steps(2);
         req_n = 4'b1101;
         steps(2);
      end
      steps(3);
      chk("t4_ovf5",   ovf1, 5);
      chk("t4_sat_w2", ovf2, 3);

      // event on bit 0 in the same cycle bit 0 is loaded
      req_n = 4'hF;
      ready = 1'b1;
      steps(4);
      ready = 1'b0;
      req_n = 4'b1110;
      steps(4);
      chk("t5_code", {a1, b1}, 2'b00);
      chk("t5_valid", valid1, 1);
      req_n = 4'hF;
      steps(2);
      req_n = 4'b1110;
      steps(3);
      chk("t5_pend_a", pend1, 4'b0001);
      req_n = 4'hF;
      steps(2);
      req_n = 4'b1110;
      steps(2);
      ready = 1'b1;
      step();
      chk("t5_pend_kept", pend1, 4'b0001);
      chk("t5_ovf_same",  ovf1, 5);
      chk("t5_valid_b",   valid1, 1);
      step();
      chk("t5_pend_done", pend1, 4'b0000);
      chk("t5_valid_c",   valid1, 1);
      step();
      chk("t5_idle", valid1, 0);

      // asynchronous reset mid-operation
      ready = 1'b0;
      req_n = 4'hF;
      steps(3);
      req_n = 4'b0111;
      steps(4);
      req_n = 4'b0001;
      steps(3);
      chk("t6_pend", pend1, 4'b0110);
      chk("t6_valid", valid1, 1);
      #2;
      rst   = 1'b1;
      req_n = 4'b1011;
      #1;
      chk_reset_vals("t6_async");
      model_reset();
      steps(2);
      rst   = 1'b0;
      ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t6_post_valid", valid1, (k == 4));
         if (k == 4) chk("t6_post_code", {a1, b1}, 2'b10);
      end

      // randomized phase
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 5) == 0) req_n[i] = ~req_n[i];
         end
         if ((c % 400) < 120) ready = ($urandom_range(0, 7) == 0);
         else                 ready = ($urandom_range(0, 3) != 0);
         if (c == 1000) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            compare_all();
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
